// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb_pkg
// Purpose  : Shared types and default widths for the instruction/data TCM
//            port arbiter (mem_port_arbiter).
// Contents : owner_e   - which requester owns the read data returning next
//                        cycle
//            c_def_data_w / c_def_strb_w - default data and byte-strobe widths
//            strb_width() - byte-strobe width for a given data width
// Revision : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

  localparam int unsigned c_def_data_w = 32;
  localparam int unsigned c_def_strb_w = c_def_data_w / 8;

  // Owner of the response that the memory delivers one cycle after a grant.
  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_INSTR = 2'd1,
    OWN_DATA  = 2'd2
  } owner_e;

  function automatic int unsigned strb_width(input int unsigned data_w);
    return data_w / 8;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter_if
// Purpose  : Bundles the instruction-fetch port, the data port, the single
//            memory port and the conflict counter of mem_port_arbiter.
// Modports : slave  - the arbiter (consumes requests, drives memory side)
//            master - the environment (pipeline requesters and memory)
// Params   : ADDR_W - address width, DATA_W - data width (strobes DATA_W/8)
// Revision : 1.0 - initial release
// ============================================================================
interface mem_port_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = c_def_data_w
);
  localparam int unsigned STRB_W = strb_width(DATA_W);

  // Instruction fetch port
  logic              ireq_valid_i;
  logic [ADDR_W-1:0] ireq_addr_i;
  logic              ireq_ready_o;
  logic              iresp_valid_o;
  logic [DATA_W-1:0] iresp_data_o;

  // Data (load/store) port
  logic              dreq_valid_i;
  logic [ADDR_W-1:0] dreq_addr_i;
  logic [STRB_W-1:0] dreq_wr_i;
  logic [DATA_W-1:0] dreq_data_i;
  logic              dreq_ready_o;
  logic              dresp_valid_o;
  logic [DATA_W-1:0] dresp_data_o;

  // Single memory port
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_data_o;
  logic [STRB_W-1:0] mem_wr_o;
  logic [DATA_W-1:0] mem_data_i;

  // Statistics
  logic [31:0]       conflict_cnt_o;

  modport slave (
    input  ireq_valid_i, ireq_addr_i,
    output ireq_ready_o, iresp_valid_o, iresp_data_o,
    input  dreq_valid_i, dreq_addr_i, dreq_wr_i, dreq_data_i,
    output dreq_ready_o, dresp_valid_o, dresp_data_o,
    output mem_addr_o, mem_data_o, mem_wr_o,
    input  mem_data_i,
    output conflict_cnt_o
  );

  modport master (
    output ireq_valid_i, ireq_addr_i,
    input  ireq_ready_o, iresp_valid_o, iresp_data_o,
    output dreq_valid_i, dreq_addr_i, dreq_wr_i, dreq_data_i,
    input  dreq_ready_o, dresp_valid_o, dresp_data_o,
    input  mem_addr_o, mem_data_o, mem_wr_o,
    output mem_data_i,
    input  conflict_cnt_o
  );

endinterface
`default_nettype wire

// File: rtl/arb_starve_counter.sv
`default_nettype none
// ============================================================================
// Module   : arb_starve_counter
// Purpose  : Counts consecutive cycles in which the instruction port is
//            requesting but not granted. Once the count reaches STARVE_LIMIT,
//            force_grant requests that the next cycle go to the instruction
//            port regardless of data traffic. Used only when the arbiter is
//            built with ARB_STARVE_GUARD_EN.
// Ports    : clk_i, rst_i (async, active-high)
//            ireq_valid  - instruction request present this cycle
//            instr_grant - instruction request granted this cycle
//            force_grant - instruction port must win this cycle
// Revision : 1.0 - initial release
// ============================================================================
module arb_starve_counter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  wire logic clk_i,
  input  wire logic rst_i,
  input  wire logic ireq_valid,
  input  wire logic instr_grant,
  output logic      force_grant
);

  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] c_limit = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt <= '0;
    end else if (!ireq_valid || instr_grant) begin
      r_cnt <= '0;
    end else if (r_cnt != c_limit) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // The count can only sit at the limit while the fetch is still waiting,
  // but qualifying with ireq_valid keeps a dropped request from winning.
  assign force_grant = ireq_valid && (r_cnt == c_limit);

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one single-ported synchronous byte-strobed TCM between the
//            instruction-fetch and data ports. One grant per cycle, data port
//            has fixed priority; read data returns to its owner one cycle
//            after the grant.
// Ports    : clk_i, rst_i (async, active-high)
//            bus (mem_port_arbiter_if.slave): ireq_*, iresp_*, dreq_*,
//            dresp_*, mem_*, conflict_cnt_o
// Options  : ARB_STARVE_GUARD_EN - after STARVE_LIMIT consecutive denied
//            fetch cycles, the next cycle is granted to the fetch port even
//            when a data request is present.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = c_def_data_w,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  wire logic       clk_i,
  input  wire logic       rst_i,
  mem_port_arbiter_if.slave bus
);

  localparam int unsigned STRB_W = strb_width(DATA_W);

  owner_e              r_owner;
  owner_e              w_owner_nxt;
  logic [ADDR_W-1:0]   r_last_addr;
  logic [31:0]         r_conflict_cnt;

  logic                w_force;
  logic                w_igrant;
  logic                w_dgrant;
  logic [ADDR_W-1:0]   w_mem_addr;
  logic [DATA_W-1:0]   w_mem_data;
  logic [STRB_W-1:0]   w_mem_wr;

`ifdef ARB_STARVE_GUARD_EN
  arb_starve_counter #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .ireq_valid  (bus.ireq_valid_i),
    .instr_grant (w_igrant),
    .force_grant (w_force)
  );
`else
  // Strict data priority; STARVE_LIMIT has no effect in this build.
  assign w_force = 1'b0 & (STARVE_LIMIT == 0);
`endif

  // Grant selection. Everything is held off while reset is asserted so the
  // memory sees no access and the requesters see no acceptance.
  always_comb begin
    w_igrant = 1'b0;
    w_dgrant = 1'b0;
    if (!rst_i) begin
      if (w_force && bus.ireq_valid_i) begin
        w_igrant = 1'b1;
      end else if (bus.dreq_valid_i) begin
        w_dgrant = 1'b1;
      end else if (bus.ireq_valid_i) begin
        w_igrant = 1'b1;
      end
    end
  end

  // Memory-side drive and next response owner.
  always_comb begin
    w_mem_addr  = r_last_addr;
    w_mem_data  = '0;
    w_mem_wr    = '0;
    w_owner_nxt = OWN_NONE;
    if (rst_i) begin
      w_mem_addr = '0;
    end else if (w_dgrant) begin
      w_mem_addr  = bus.dreq_addr_i;
      w_mem_data  = bus.dreq_data_i;
      w_mem_wr    = bus.dreq_wr_i;
      // Stores produce no response.
      w_owner_nxt = (bus.dreq_wr_i == '0) ? OWN_DATA : OWN_NONE;
    end else if (w_igrant) begin
      w_mem_addr  = bus.ireq_addr_i;
      w_owner_nxt = OWN_INSTR;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_owner     <= OWN_NONE;
      r_last_addr <= '0;
    end else begin
      r_owner     <= w_owner_nxt;
      r_last_addr <= w_mem_addr;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_conflict_cnt <= '0;
    end else if (bus.ireq_valid_i && bus.dreq_valid_i && (r_conflict_cnt != '1)) begin
      r_conflict_cnt <= r_conflict_cnt + 32'd1;
    end
  end

  assign bus.ireq_ready_o   = w_igrant;
  assign bus.dreq_ready_o   = w_dgrant;
  assign bus.mem_addr_o     = w_mem_addr;
  assign bus.mem_data_o     = w_mem_data;
  assign bus.mem_wr_o       = w_mem_wr;

  // The memory returns data one cycle after the address; r_owner says whose
  // it is. Both data outputs follow the memory, only the valid is steered.
  assign bus.iresp_valid_o  = (r_owner == OWN_INSTR);
  assign bus.dresp_valid_o  = (r_owner == OWN_DATA);
  assign bus.iresp_data_o   = bus.mem_data_i;
  assign bus.dresp_data_o   = bus.mem_data_i;

  assign bus.conflict_cnt_o = r_conflict_cnt;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Self-checking bench for mem_port_arbiter. A behavioural model
//            (grant rule, pending-response queue entry, shadow memory image,
//            conflict and starvation counts) predicts every output; a simple
//            memory device answers the DUT's memory port.
// Options  : ARB_STARVE_GUARD_EN - expectations follow the guarded build.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int unsigned ADDR_W       = 32;
  localparam int unsigned DATA_W       = 32;
  localparam int unsigned STARVE_LIMIT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_port_arbiter #(
    .ADDR_W       (ADDR_W),
    .DATA_W       (DATA_W),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  int n_vec = 0;
  int n_err = 0;

  // ---------------- memory contents ----------------
  function automatic logic [31:0] init_word(input logic [29:0] w);
    return {w[13:0], 2'b01, w[15:0]} ^ 32'h5A3C_96E1;
  endfunction

  logic [31:0] dev_mem [logic [29:0]];
  logic [31:0] sh_mem  [logic [29:0]];

  // Memory device: read data appears one cycle after the address.
  always @(posedge clk) begin : dev
    logic [29:0] w;
    logic [31:0] cur;
    w   = bus.mem_addr_o[31:2];
    cur = dev_mem.exists(w) ? dev_mem[w] : init_word(w);
    bus.mem_data_i <= cur;
    if (|bus.mem_wr_o) begin
      for (int b = 0; b < 4; b++)
        if (bus.mem_wr_o[b]) cur[8*b +: 8] = bus.mem_data_o[8*b +: 8];
      dev_mem[w] = cur;
    end
  end

  function automatic logic [31:0] sh_read(input logic [31:0] a);
    if (sh_mem.exists(a[31:2])) return sh_mem[a[31:2]];
    return init_word(a[31:2]);
  endfunction

  // ---------------- reference model ----------------
  int          exp_kind;     // 0 none, 1 fetch response, 2 load response
  logic [31:0] exp_pdata;
  int          conf_model;
  int          streak;
  logic [31:0] last_addr;
  logic        c_iv, c_dv;
  logic [31:0] c_ia, c_da, c_dd;
  logic [3:0]  c_dw;
  logic        e_ig, e_dg;
  logic [31:0] e_addr;
  logic [3:0]  e_wr;

  task automatic model_reset();
    exp_kind   = 0;
    exp_pdata  = '0;
    conf_model = 0;
    streak     = 0;
    last_addr  = '0;
  endtask

  // Drive one cycle's requests just after the edge, then form expectations
  // at the falling edge where the bench samples.
  task automatic apply(input logic iv, input logic [31:0] ia, input logic dv,
                       input logic [31:0] da, input logic [3:0] dw, input logic [31:0] dd);
    logic forced;
    bus.ireq_valid_i = iv;  bus.ireq_addr_i = ia;
    bus.dreq_valid_i = dv;  bus.dreq_addr_i = da;
    bus.dreq_wr_i    = dw;  bus.dreq_data_i = dd;
    c_iv = iv; c_ia = ia; c_dv = dv; c_da = da; c_dw = dw; c_dd = dd;
    @(negedge clk);
    forced = 1'b0;
`ifdef ARB_STARVE_GUARD_EN
    forced = iv && (streak >= STARVE_LIMIT);
`endif
    e_ig   = iv && (forced || !dv);
    e_dg   = dv && !e_ig;
    e_addr = e_dg ? da : (e_ig ? ia : last_addr);
    e_wr   = e_dg ? dw : 4'h0;
  endtask

  task automatic advance();
    logic [31:0] cur;
    @(posedge clk);
    exp_kind = 0;
    if (e_dg && c_dw == 4'h0) begin
      exp_kind  = 2;
      exp_pdata = sh_read(c_da);
    end else if (e_dg) begin
      cur = sh_read(c_da);
      for (int b = 0; b < 4; b++)
        if (c_dw[b]) cur[8*b +: 8] = c_dd[8*b +: 8];
      sh_mem[c_da[31:2]] = cur;
    end else if (e_ig) begin
      exp_kind  = 1;
      exp_pdata = sh_read(c_ia);
    end
    if (c_iv && c_dv) conf_model++;
    streak    = (e_ig || !c_iv) ? 0 : streak + 1;
    last_addr = e_addr;
    #1;
  endtask

  task automatic idle();
    apply(1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    bus.ireq_valid_i = 1'b1; bus.ireq_addr_i = 32'h0040_0000;
    bus.dreq_valid_i = 1'b1; bus.dreq_addr_i = 32'h1001_0000;
    bus.dreq_wr_i = 4'hF;    bus.dreq_data_i = 32'h1234_5678;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_vec++; if (bus.ireq_ready_o !== 1'b0) begin n_err++; $display("FAIL reset_iready got %b want 0", bus.ireq_ready_o); end
    n_vec++; if (bus.dreq_ready_o !== 1'b0) begin n_err++; $display("FAIL reset_dready got %b want 0", bus.dreq_ready_o); end
    n_vec++; if (bus.iresp_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_ivalid got %b want 0", bus.iresp_valid_o); end
    n_vec++; if (bus.dresp_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_dvalid got %b want 0", bus.dresp_valid_o); end
    n_vec++; if (bus.mem_wr_o !== 4'h0) begin n_err++; $display("FAIL reset_mem_wr got %h want 0", bus.mem_wr_o); end
    n_vec++; if (bus.mem_addr_o !== 32'h0) begin n_err++; $display("FAIL reset_mem_addr got %h want 0", bus.mem_addr_o); end
    n_vec++; if (bus.mem_data_o !== 32'h0) begin n_err++; $display("FAIL reset_mem_data got %h want 0", bus.mem_data_o); end
    n_vec++; if (bus.conflict_cnt_o !== 32'h0) begin n_err++; $display("FAIL reset_conflict got %0d want 0", bus.conflict_cnt_o); end
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    for (int k = 0; k < 2; k++) begin
      idle();
      n_vec++; if (bus.iresp_valid_o !== 1'b0 || bus.dresp_valid_o !== 1'b0) begin
        n_err++; $display("FAIL post_reset_resp got i=%b d=%b want 0 0", bus.iresp_valid_o, bus.dresp_valid_o);
      end
      advance();
    end
  endtask

  task automatic test_instr_only();
    apply(1'b1, 32'h0040_0000, 1'b0, 32'h0, 4'h0, 32'h0);
    n_vec++; if (bus.ireq_ready_o !== 1'b1 || bus.mem_addr_o !== 32'h0040_0000 || bus.mem_wr_o !== 4'h0) begin
      n_err++; $display("FAIL fetch0_grant got rdy=%b addr=%h wr=%h want 1 00400000 0", bus.ireq_ready_o, bus.mem_addr_o, bus.mem_wr_o);
    end
    advance();
    apply(1'b1, 32'h0040_0004, 1'b0, 32'h0, 4'h0, 32'h0);
    n_vec++; if (bus.ireq_ready_o !== 1'b1 || bus.mem_addr_o !== 32'h0040_0004) begin
      n_err++; $display("FAIL fetch1_grant got rdy=%b addr=%h want 1 00400004", bus.ireq_ready_o, bus.mem_addr_o);
    end
    n_vec++; if (bus.iresp_valid_o !== 1'b1 || bus.iresp_data_o !== sh_read(32'h0040_0000)) begin
      n_err++; $display("FAIL fetch0_resp got v=%b d=%h want 1 %h", bus.iresp_valid_o, bus.iresp_data_o, sh_read(32'h0040_0000));
    end
    advance();
    idle();
    n_vec++; if (bus.iresp_valid_o !== 1'b1 || bus.iresp_data_o !== sh_read(32'h0040_0004)) begin
      n_err++; $display("FAIL fetch1_resp got v=%b d=%h want 1 %h", bus.iresp_valid_o, bus.iresp_data_o, sh_read(32'h0040_0004));
    end
    advance();
  endtask

  task automatic test_conflict();
    apply(1'b1, 32'h0040_0008, 1'b1, 32'h1001_0000, 4'h0, 32'h0);
    n_vec++; if (bus.dreq_ready_o !== 1'b1 || bus.ireq_ready_o !== 1'b0 || bus.mem_addr_o !== 32'h1001_0000) begin
      n_err++; $display("FAIL conflict_first got d=%b i=%b addr=%h want 1 0 10010000", bus.dreq_ready_o, bus.ireq_ready_o, bus.mem_addr_o);
    end
    advance();
    apply(1'b1, 32'h0040_0008, 1'b0, 32'h0, 4'h0, 32'h0);
    n_vec++; if (bus.ireq_ready_o !== 1'b1 || bus.dresp_valid_o !== 1'b1 || bus.iresp_valid_o !== 1'b0) begin
      n_err++; $display("FAIL conflict_second got irdy=%b dv=%b iv=%b want 1 1 0", bus.ireq_ready_o, bus.dresp_valid_o, bus.iresp_valid_o);
    end
    n_vec++; if (bus.dresp_data_o !== sh_read(32'h1001_0000)) begin
      n_err++; $display("FAIL conflict_ddata got %h want %h", bus.dresp_data_o, sh_read(32'h1001_0000));
    end
    advance();
    idle();
    n_vec++; if (bus.iresp_valid_o !== 1'b1 || bus.dresp_valid_o !== 1'b0 || bus.iresp_data_o !== sh_read(32'h0040_0008)) begin
      n_err++; $display("FAIL conflict_iresp got iv=%b dv=%b d=%h want 1 0 %h", bus.iresp_valid_o, bus.dresp_valid_o, bus.iresp_data_o, sh_read(32'h0040_0008));
    end
    n_vec++; if (bus.conflict_cnt_o !== 32'd1) begin
      n_err++; $display("FAIL conflict_cnt got %0d want 1", bus.conflict_cnt_o);
    end
    advance();
  endtask

  task automatic test_store_load();
    logic [31:0] base, want;
    base = init_word(30'h0400_4001);   // word 0x10010004 >> 2, never written before
    want = {base[31:16], 16'hCCDD};
    apply(1'b0, 32'h0, 1'b1, 32'h1001_0004, 4'b0011, 32'hAABB_CCDD);
    n_vec++; if (bus.dreq_ready_o !== 1'b1 || bus.mem_wr_o !== 4'b0011 || bus.mem_data_o !== 32'hAABB_CCDD) begin
      n_err++; $display("FAIL store_drive got rdy=%b wr=%b data=%h want 1 0011 aabbccdd", bus.dreq_ready_o, bus.mem_wr_o, bus.mem_data_o);
    end
    advance();
    apply(1'b0, 32'h0, 1'b1, 32'h1001_0004, 4'h0, 32'h0);
    n_vec++; if (bus.dresp_valid_o !== 1'b0 || bus.mem_wr_o !== 4'h0) begin
      n_err++; $display("FAIL store_noresp got dv=%b wr=%h want 0 0", bus.dresp_valid_o, bus.mem_wr_o);
    end
    advance();
    idle();
    n_vec++; if (bus.dresp_valid_o !== 1'b1 || bus.dresp_data_o !== want) begin
      n_err++; $display("FAIL load_after_store got v=%b d=%h want 1 %h", bus.dresp_valid_o, bus.dresp_data_o, want);
    end
    advance();
  endtask

  task automatic test_starve();
    int          first_ig, want_first;
    logic [31:0] ia, da;
    first_ig = -1;
    ia = 32'h0040_0010;
    da = 32'h1001_0020;
    for (int k = 1; k <= 10; k++) begin
      apply(1'b1, ia, 1'b1, da, 4'h0, 32'h0);
      n_vec++; if (bus.ireq_ready_o !== e_ig || bus.dreq_ready_o !== e_dg) begin
        n_err++; $display("FAIL starve_grant cyc%0d got i=%b d=%b want %b %b", k, bus.ireq_ready_o, bus.dreq_ready_o, e_ig, e_dg);
      end
      if (bus.ireq_ready_o === 1'b1 && first_ig < 0) first_ig = k;
      if (bus.ireq_ready_o === 1'b1) ia = ia + 32'd4;
      if (bus.dreq_ready_o === 1'b1) da = da + 32'd4;
      advance();
    end
`ifdef ARB_STARVE_GUARD_EN
    want_first = STARVE_LIMIT + 1;
`else
    want_first = -1;
`endif
    n_vec++; if (first_ig != want_first) begin
      n_err++; $display("FAIL starve_first_grant got %0d want %0d", first_ig, want_first);
    end
    idle();
    n_vec++; if (bus.iresp_valid_o !== (exp_kind == 1) || bus.dresp_valid_o !== (exp_kind == 2)) begin
      n_err++; $display("FAIL starve_drain got i=%b d=%b want kind %0d", bus.iresp_valid_o, bus.dresp_valid_o, exp_kind);
    end
    advance();
  endtask

  task automatic test_midop_reset();
    apply(1'b0, 32'h0, 1'b1, 32'h1001_0008, 4'h0, 32'h0);
    n_vec++; if (bus.dreq_ready_o !== 1'b1) begin
      n_err++; $display("FAIL midop_grant got %b want 1", bus.dreq_ready_o);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    bus.dreq_valid_i = 1'b0;
    @(negedge clk);
    n_vec++; if (bus.dresp_valid_o !== 1'b0 || bus.iresp_valid_o !== 1'b0) begin
      n_err++; $display("FAIL midop_in_reset got d=%b i=%b want 0 0", bus.dresp_valid_o, bus.iresp_valid_o);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    idle();
    n_vec++; if (bus.dresp_valid_o !== 1'b0 || bus.iresp_valid_o !== 1'b0 || bus.conflict_cnt_o !== 32'h0) begin
      n_err++; $display("FAIL midop_after got d=%b i=%b cnt=%0d want 0 0 0", bus.dresp_valid_o, bus.iresp_valid_o, bus.conflict_cnt_o);
    end
    advance();
  endtask

  task automatic test_random();
    logic        i_pend, d_pend;
    logic [31:0] i_addr, d_addr, d_data;
    logic [3:0]  d_wr;
    i_pend = 1'b0; d_pend = 1'b0;
    i_addr = '0; d_addr = '0; d_data = '0; d_wr = '0;
    for (int k = 0; k < 400; k++) begin
      if (!i_pend && ($urandom % 3) != 0) begin
        i_pend = 1'b1;
        i_addr = 32'h0040_0000 | (32'($urandom % 16) << 2);
      end
      if (!d_pend && ($urandom % 2) != 0) begin
        d_pend = 1'b1;
        d_addr = 32'h1001_0000 | (32'($urandom % 16) << 2);
        d_wr   = (($urandom % 3) == 0) ? 4'($urandom) : 4'h0;
        d_data = $urandom;
      end
      apply(i_pend, i_addr, d_pend, d_addr, d_wr, d_data);
      n_vec++; if (bus.ireq_ready_o !== e_ig || bus.dreq_ready_o !== e_dg) begin
        n_err++; $display("FAIL rnd_grant cyc%0d got i=%b d=%b want %b %b", k, bus.ireq_ready_o, bus.dreq_ready_o, e_ig, e_dg);
      end
      n_vec++; if (bus.mem_addr_o !== e_addr || bus.mem_wr_o !== e_wr) begin
        n_err++; $display("FAIL rnd_mem cyc%0d got addr=%h wr=%h want %h %h", k, bus.mem_addr_o, bus.mem_wr_o, e_addr, e_wr);
      end
      if (e_dg) begin
        n_vec++; if (bus.mem_data_o !== d_data) begin
          n_err++; $display("FAIL rnd_wdata cyc%0d got %h want %h", k, bus.mem_data_o, d_data);
        end
      end
      n_vec++; if (bus.iresp_valid_o !== (exp_kind == 1) || bus.dresp_valid_o !== (exp_kind == 2)) begin
        n_err++; $display("FAIL rnd_rvalid cyc%0d got i=%b d=%b want kind %0d", k, bus.iresp_valid_o, bus.dresp_valid_o, exp_kind);
      end
      if (exp_kind == 1) begin
        n_vec++; if (bus.iresp_data_o !== exp_pdata) begin
          n_err++; $display("FAIL rnd_idata cyc%0d got %h want %h", k, bus.iresp_data_o, exp_pdata);
        end
      end
      if (exp_kind == 2) begin
        n_vec++; if (bus.dresp_data_o !== exp_pdata) begin
          n_err++; $display("FAIL rnd_ddata cyc%0d got %h want %h", k, bus.dresp_data_o, exp_pdata);
        end
      end
      n_vec++; if (bus.conflict_cnt_o !== 32'(conf_model)) begin
        n_err++; $display("FAIL rnd_conflict cyc%0d got %0d want %0d", k, bus.conflict_cnt_o, conf_model);
      end
      if (bus.ireq_ready_o === 1'b1) i_pend = 1'b0;
      if (bus.dreq_ready_o === 1'b1) d_pend = 1'b0;
      advance();
    end
  endtask

  initial begin
    bus.ireq_valid_i = 1'b0; bus.ireq_addr_i = '0;
    bus.dreq_valid_i = 1'b0; bus.dreq_addr_i = '0;
    bus.dreq_wr_i    = '0;   bus.dreq_data_i = '0;
    model_reset();
    test_reset();
    test_instr_only();
    test_conflict();
    test_store_load();
    test_starve();
    test_midop_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one single-ported, synchronous, byte-strobed TCM between the pipeline's instruction-fetch port and its data (load/store) port. One request is granted per cycle, with fixed priority to the data port. Read data is returned to the owning requester one cycle after the grant. Sits between RISCV_PIPELINE and a single-port instance of the memory, replacing the dual-port arrangement.

Parameters:
ADDR_W, 32, address width of both requesters and the memory
DATA_W, 32, data width; byte-strobe width is DATA_W/8
STARVE_LIMIT, 4, consecutive denied instruction cycles before a forced instruction grant (used only with the optional feature)

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-high
ireq_valid_i  in  1  instruction fetch request
ireq_addr_i  in  ADDR_W  fetch address
ireq_ready_o  out  1  fetch accepted this cycle
iresp_valid_o  out  1  fetch data valid
iresp_data_o  out  DATA_W  fetched instruction
dreq_valid_i  in  1  data request
dreq_addr_i  in  ADDR_W  data address
dreq_wr_i  in  DATA_W/8  byte write strobes; all zero means read
dreq_data_i  in  DATA_W  store data
dreq_ready_o  out  1  data request accepted this cycle
dresp_valid_o  out  1  load data valid
dresp_data_o  out  DATA_W  load data
mem_addr_o  out  ADDR_W  memory address
mem_data_o  out  DATA_W  memory write data
mem_wr_o  out  DATA_W/8  memory byte strobes
mem_data_i  in  DATA_W  memory read data, valid one cycle after address
conflict_cnt_o  out  32  cycles in which both requesters were valid

Behaviour:
- Reset, asynchronous, active-high:
  - all ready, resp_valid, mem_wr_o and conflict_cnt_o are 0; mem_addr_o and mem_data_o are 0.
  - The response owner register is cleared to OWN_NONE and the starvation counter to 0.
- Arbitration is combinational within the cycle.
  - If dreq_valid_i: grant data. dreq_ready_o=1; mem_addr_o, mem_wr_o and mem_data_o come from the data port.
  - Else if ireq_valid_i: grant instruction. ireq_ready_o=1; mem_wr_o=0.
  - Else: no grant. mem_wr_o=0; mem_addr_o holds its last value.
- A requester holds valid/addr/data stable until it sees ready. A requester that is not granted keeps valid asserted.
- Response owner register (OWN_NONE / OWN_INSTR / OWN_DATA) is updated every cycle:
  - OWN_DATA on a data read grant, where dreq_wr_i is 0.
  - OWN_INSTR on an instruction grant.
  - OWN_NONE on a write grant or idle.
- Response path, one cycle after the grant:
  - iresp_valid_o=(owner==OWN_INSTR), dresp_valid_o=(owner==OWN_DATA).
  - Both response data outputs are driven from mem_data_i.
  - Writes produce no response.
- Throughput: one transaction per cycle with no bubbles; back-to-back grants to the same or different ports are allowed.
- conflict_cnt_o increments by 1 in each cycle with ireq_valid_i && dreq_valid_i. It saturates at 0xFFFFFFFF.
- Reset asserted mid-transaction: the pending response is dropped and the response valids stay 0 after reset release.
- Addresses pass through unmodified. Alignment is the requester's responsibility.

Optional Feature:
- Macro: ARB_STARVE_GUARD_EN.
- Defined:
  - The starvation counter counts consecutive cycles with ireq_valid_i=1 and no instruction grant.
  - When it reaches STARVE_LIMIT, the next cycle grants instruction even if dreq_valid_i is 1 (dreq_ready_o=0).
  - The counter clears on any instruction grant or when ireq_valid_i=0.
- Undefined: strict data priority; the counter logic is absent.

Decomposition:
- Package mem_arb_pkg: owner_e enum (OWN_NONE, OWN_INSTR, OWN_DATA) and a default width localparam for the strobe width.
- Optional sub-module arb_starve_counter: counter, limit compare and clear, instantiated only under ARB_STARVE_GUARD_EN.

Test Plan:
- Reset: rst_i=1 with both requesters valid -> all outputs 0. After release, no resp_valid until a grant occurs.
- Instruction only: fetches at 0x00400000, 0x00400004 on consecutive cycles -> ireq_ready_o=1 both cycles; iresp_valid_o one cycle later each time, data = memory words at those addresses.
- Conflict: both valid, dreq read 0x10010000, ireq 0x00400008 -> data granted first, instruction granted next cycle.
  - dresp_valid_o is followed by iresp_valid_o.
  - conflict_cnt_o=1.
- Store then load: dreq_wr_i=4'b0011, data 0xAABBCCDD, address 0x10010004 -> no dresp. A following read of the same address returns 0x????CCDD with the upper bytes unchanged.
- Starvation (ARB_STARVE_GUARD_EN, STARVE_LIMIT=4): dreq_valid_i held 1 for 10 cycles with ireq valid -> instruction granted on cycle 5.
  - Without the macro: no instruction grant for all 10 cycles.
- Mid-op reset: assert rst_i the cycle after a data read grant -> dresp_valid_o stays 0 and owner returns to OWN_NONE.
